bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles a grant waits for s_ack_i before abort; legal range 2..255.
REQ-002 clk_i  input  1  single system clock; all state on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 m_req_i  input  3  per-master request (bit0 fetch, bit1 LSU, bit2 debug); level, held until ack/err.
REQ-005 m_we_i  input  3  per-master write enable.
REQ-006 m_hb_i  input  6  per-master half-word/byte mode, 2 bits per master, master n at [2n+1:2n].
REQ-007 m_addr_i  input  96  per-master address, master n at [32n+31:32n].
REQ-008 m_wdata_i  input  96  per-master write data, same packing.
REQ-009 m_gnt_o  output  3  one-hot grant, registered.
REQ-010 m_ack_o  output  3  one-cycle completion pulse to granted master.
REQ-011 m_err_o  output  3  one-cycle timeout pulse to granted master.
REQ-012 s_valid_o  output  1  transaction valid toward slave bus.
REQ-013 s_addr_o / s_wdata_o / s_we_o / s_hb_o  output  32/32/1/2  muxed fields of granted master.
REQ-014 s_ack_i  input  1  slave completion, sampled only while s_valid_o=1.
REQ-015 busy_o  output  1  high whenever FSM is in GRANT.

Function
REQ-016 FSM states: IDLE, GRANT; state, grant index g, round-robin pointer last, timeout counter cnt are registers.
REQ-017 IDLE: if any m_req_i bit set, next state GRANT with g = first requester searching last+1, last+2, last+3 (mod 3); else stay IDLE.
REQ-018 m_gnt_o = one-hot(g) while in GRANT, 0 in IDLE; grant appears one cycle after request seen in IDLE.
REQ-019 s_valid_o = 1 in GRANT only; s_addr_o, s_wdata_o, s_we_o, s_hb_o combinationally select master g fields in GRANT, all 0 in IDLE.
REQ-020 GRANT with s_ack_i=1: m_ack_o[g]=1 same cycle (combinational); last<=g; cnt<=0.
REQ-021 Back-to-back: on ack cycle, arbitrate with m_req_i[g] masked; if another requester present, next state GRANT with new g (zero idle cycles); else IDLE.
REQ-022 cnt increments each GRANT cycle without ack; when cnt==TIMEOUT-1 and s_ack_i=0: m_err_o[g]=1 that cycle, last<=g, cnt<=0, next-arbitration as REQ-021.
REQ-023 Ack and timeout in same cycle: ack wins, m_err_o stays 0.
REQ-024 Granted master drops m_req_i[g] before ack: transaction abandoned, no ack/err, last<=g, cnt<=0, next state IDLE; a late s_ack_i is ignored.
REQ-025 Grant never changes mid-transaction regardless of other requests.
REQ-026 At most one bit of m_gnt_o, m_ack_o, m_err_o high in any cycle; ack/err only to the granted master.
REQ-027 Starvation bound: a continuously requesting master is granted within 2 completed transactions of others.

Reset
REQ-028 rst_i=1 at clock edge: state<=IDLE, m_gnt_o<=0, last<=2 (master 0 highest priority after reset), cnt<=0; takes priority over all events.
REQ-029 During/after reset cycle m_ack_o, m_err_o, s_valid_o, busy_o = 0; in-flight transaction abandoned, no ack/err issued.

Verification
REQ-030 After reset, m_req_i=3'b011 -> cycle+1 m_gnt_o=001; s_ack_i=1 -> m_ack_o=001, next cycle m_gnt_o=010, no idle cycle.
REQ-031 m_req_i=3'b111 held, s_ack_i=1 every GRANT cycle -> grant sequence 001,010,100,001 repeating.
REQ-032 TIMEOUT=16, single request bit1, s_ack_i=0 -> m_err_o=010 on 16th GRANT cycle, m_ack_o never set, state IDLE next if req dropped.
REQ-033 s_ack_i=1 on cycle cnt==15 with TIMEOUT=16 -> m_ack_o pulse, m_err_o=0.
REQ-034 Granted master 2 drops req at cnt=3 -> IDLE next cycle, no ack/err; then m_req_i=100 -> master 0/1 absent, master 2 regranted.
REQ-035 rst_i=1 mid-GRANT with s_ack_i=1 -> no ack pulse, m_gnt_o=0 next cycle, next arbitration favours master 0.

Source files
------------

// File: rtl/bus_arbiter.sv
// Three-master round-robin bus arbiter with a per-transaction ack timeout.
// Master 0 is instruction fetch, master 1 is the load/store unit and master 2
// is debug. One transaction is in flight at a time. The granted master's
// fields are steered onto the slave bus until the slave acks, the timeout
// expires, or the master withdraws its request.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  m_req_i,
  input  logic [2:0]  m_we_i,
  input  logic [5:0]  m_hb_i,
  input  logic [95:0] m_addr_i,
  input  logic [95:0] m_wdata_i,
  output logic [2:0]  m_gnt_o,
  output logic [2:0]  m_ack_o,
  output logic [2:0]  m_err_o,
  output logic        s_valid_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic        s_we_o,
  output logic [1:0]  s_hb_o,
  input  logic        s_ack_i,
  output logic        busy_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // The last GRANT cycle before an abort is the one where cnt reaches this.
  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [1:0] g_q, g_d;
  logic [1:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] gnt_q, gnt_d;

  logic       active;
  logic       reqHeld;
  logic       ackNow;
  logic       timeoutNow;
  logic [2:0] pick;

  // Step a master index through 0,1,2 and wrap back to 0.
  function automatic logic [1:0] wrapInc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Round-robin search starting just after ptr. Returns {found, index}.
  function automatic logic [2:0] rrPick(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] c3;
    c1 = wrapInc(ptr);
    c2 = wrapInc(c1);
    c3 = wrapInc(c2);
    if (req[c1])      return {1'b1, c1};
    else if (req[c2]) return {1'b1, c2};
    else if (req[c3]) return {1'b1, c3};
    else              return 3'b000;
  endfunction

  function automatic logic [2:0] oneHot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  // Reset forces every bus-facing strobe low, so an in-flight transfer ends silently.
  always_comb begin
    active     = (state_q == GRANT) && !rst_i;
    reqHeld    = m_req_i[g_q];
    ackNow     = active && reqHeld && s_ack_i;
    timeoutNow = active && reqHeld && !s_ack_i && (cnt_q == CNT_MAX);
    m_ack_o    = ackNow     ? gnt_q : 3'b000;
    m_err_o    = timeoutNow ? gnt_q : 3'b000;
    busy_o     = active;
    s_valid_o  = active;
  end

  // Steer the granted master's fields onto the slave bus, zero otherwise.
  always_comb begin
    s_addr_o  = 32'd0;
    s_wdata_o = 32'd0;
    s_we_o    = 1'b0;
    s_hb_o    = 2'b00;
    if (active) begin
      case (g_q)
        2'd0: begin
          s_addr_o  = m_addr_i[31:0];
          s_wdata_o = m_wdata_i[31:0];
          s_we_o    = m_we_i[0];
          s_hb_o    = m_hb_i[1:0];
        end
        2'd1: begin
          s_addr_o  = m_addr_i[63:32];
          s_wdata_o = m_wdata_i[63:32];
          s_we_o    = m_we_i[1];
          s_hb_o    = m_hb_i[3:2];
        end
        2'd2: begin
          s_addr_o  = m_addr_i[95:64];
          s_wdata_o = m_wdata_i[95:64];
          s_we_o    = m_we_i[2];
          s_hb_o    = m_hb_i[5:4];
        end
        default: begin
          s_addr_o  = 32'd0;
          s_wdata_o = 32'd0;
          s_we_o    = 1'b0;
          s_hb_o    = 2'b00;
        end
      endcase
    end
  end

  // Next-state logic. A finished transfer re-arbitrates with the finishing
  // master masked out, so a waiting requester is granted with no idle cycle.
  // A withdrawn request always returns to IDLE first.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    pick    = 3'b000;
    case (state_q)
      IDLE: begin
        pick = rrPick(m_req_i, last_q);
        if (pick[2]) begin
          state_d = GRANT;
          g_d     = pick[1:0];
          gnt_d   = oneHot(pick[1:0]);
          cnt_d   = 8'd0;
        end
      end
      GRANT: begin
        if (!reqHeld) begin
          state_d = IDLE;
          last_d  = g_q;
          cnt_d   = 8'd0;
          gnt_d   = 3'b000;
        end else if (s_ack_i || (cnt_q == CNT_MAX)) begin
          last_d = g_q;
          cnt_d  = 8'd0;
          pick   = rrPick(m_req_i & ~gnt_q, g_q);
          if (pick[2]) begin
            state_d = GRANT;
            g_d     = pick[1:0];
            gnt_d   = oneHot(pick[1:0]);
          end else begin
            state_d = IDLE;
            gnt_d   = 3'b000;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
      end
    endcase
  end

  // State registers. Reset points the round-robin pointer at master 2 so
  // master 0 is searched first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      g_q     <= 2'd0;
      last_q  <= 2'd2;
      cnt_q   <= 8'd0;
      gnt_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  assign m_gnt_o = gnt_q;

endmodule
